// File: rtl/uart_reg_bank.sv
// uart_reg_bank: byte-protocol register bank behind a UART RX/TX pair.
// Header byte {W, 3'b000, A}; a write is followed by a data byte. Reads of
// address 0xF return {OVR, TOUT, CSERR, pad, keys} and clear the sticky flags.
// Optional macro UART_REG_BANK_CSUM_EN: write frames carry a third byte
// (header ^ data) that must match before the write is performed.
module uart_reg_bank #(
    parameter int unsigned NUM_REGS     = 4,
    parameter int unsigned NUM_KEYS     = 2,
    parameter int unsigned TIMEOUT_CLKS = 24000
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_L,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    input  logic                  i_TX_Done,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    input  logic [NUM_KEYS-1:0]   i_Keys,
    output logic [NUM_REGS*8-1:0] o_Regs,
    output logic                  o_Busy
);

    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CLKS);
    localparam int unsigned REGS_W = NUM_REGS * 8;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] GET_DATA  = 3'd1;
    localparam logic [2:0] SEND      = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
`ifdef UART_REG_BANK_CSUM_EN
    localparam logic [2:0] GET_CSUM  = 3'd4;
`endif

    localparam logic [7:0] RESP_ERR  = 8'hEE;
`ifdef UART_REG_BANK_CSUM_EN
    localparam logic [7:0] RESP_CSUM = 8'hEC;
`endif

    logic [2:0]        state_q, state_d;
    logic [3:0]        addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        resp_q, resp_d;
    logic [REGS_W-1:0] regs_q, regs_d;
    logic              ovr_q, ovr_d;
    logic              tout_q, tout_d;
    logic              cserr_q, cserr_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              busy_q, busy_d;
`ifdef UART_REG_BANK_CSUM_EN
    logic [7:0]        hdr_q, hdr_d;
    logic [7:0]        data_q, data_d;
`endif

    logic [7:0]        status_c;
    logic [7:0]        rd_byte_c;
    logic              hdr_valid_c;
    logic              addr_hit_c;

    // Status byte and read-data mux for the address carried by an incoming header
    always_comb begin
        status_c                 = 8'h00;
        status_c[NUM_KEYS-1:0]   = i_Keys;
        status_c[7]              = ovr_q;
        status_c[6]              = tout_q;
        status_c[5]              = cserr_q;
        rd_byte_c                = 8'h00;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (i_RX_Byte[3:0] == 4'(i)) begin
                rd_byte_c = regs_q[8*i +: 8];
            end
        end
        hdr_valid_c = (i_RX_Byte[6:4] == 3'b000);
        addr_hit_c  = (32'(addr_q) < NUM_REGS);
    end

    // Next-state and next-output logic for the command FSM
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        regs_d    = regs_q;
        ovr_d     = ovr_q;
        tout_d    = tout_q;
        cserr_d   = cserr_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
`ifdef UART_REG_BANK_CSUM_EN
        hdr_d     = hdr_q;
        data_d    = data_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_RX_DV) begin
                    if (!hdr_valid_c) begin
                        resp_d  = RESP_ERR;
                        state_d = SEND;
                    end else if (!i_RX_Byte[7]) begin
                        if (32'(i_RX_Byte[3:0]) < NUM_REGS) begin
                            resp_d = rd_byte_c;
                        end else if (i_RX_Byte[3:0] == 4'hF) begin
                            resp_d  = status_c;
                            ovr_d   = 1'b0;
                            tout_d  = 1'b0;
                            cserr_d = 1'b0;
                        end else begin
                            resp_d = RESP_ERR;
                        end
                        state_d = SEND;
                    end else begin
                        addr_d  = i_RX_Byte[3:0];
                        cnt_d   = '0;
                        state_d = GET_DATA;
`ifdef UART_REG_BANK_CSUM_EN
                        hdr_d   = i_RX_Byte;
`endif
                    end
                end
            end
            GET_DATA: begin
                if (i_RX_DV) begin
`ifdef UART_REG_BANK_CSUM_EN
                    data_d  = i_RX_Byte;
                    cnt_d   = '0;
                    state_d = GET_CSUM;
`else
                    if (addr_hit_c) begin
                        for (int i = 0; i < int'(NUM_REGS); i++) begin
                            if (addr_q == 4'(i)) begin
                                regs_d[8*i +: 8] = i_RX_Byte;
                            end
                        end
                        resp_d = i_RX_Byte;
                    end else begin
                        resp_d = RESP_ERR;
                    end
                    state_d = SEND;
`endif
                end else if (cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
                    tout_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_REG_BANK_CSUM_EN
            GET_CSUM: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte != (hdr_q ^ data_q)) begin
                        cserr_d = 1'b1;
                        resp_d  = RESP_CSUM;
                    end else if (addr_hit_c) begin
                        for (int i = 0; i < int'(NUM_REGS); i++) begin
                            if (addr_q == 4'(i)) begin
                                regs_d[8*i +: 8] = data_q;
                            end
                        end
                        resp_d = data_q;
                    end else begin
                        resp_d = RESP_ERR;
                    end
                    state_d = SEND;
                end else if (cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
                    tout_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            SEND: begin
                tx_dv_d   = 1'b1;
                tx_byte_d = resp_q;
                if (i_RX_DV) begin
                    ovr_d = 1'b1;
                end
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_RX_DV) begin
                    ovr_d = 1'b1;
                end
                if (i_TX_Done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            addr_q    <= 4'h0;
            cnt_q     <= '0;
            resp_q    <= 8'h00;
            regs_q    <= '0;
            ovr_q     <= 1'b0;
            tout_q    <= 1'b0;
            cserr_q   <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            busy_q    <= 1'b0;
`ifdef UART_REG_BANK_CSUM_EN
            hdr_q     <= 8'h00;
            data_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            regs_q    <= regs_d;
            ovr_q     <= ovr_d;
            tout_q    <= tout_d;
            cserr_q   <= cserr_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            busy_q    <= busy_d;
`ifdef UART_REG_BANK_CSUM_EN
            hdr_q     <= hdr_d;
            data_q    <= data_d;
`endif
        end
    end

    assign o_TX_DV   = tx_dv_q;
    assign o_TX_Byte = tx_byte_q;
    assign o_Regs    = regs_q;
    assign o_Busy    = busy_q;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed bench for uart_reg_bank: reads, writes, error responses, timeout,
// overrun and (with UART_REG_BANK_CSUM_EN) checksummed writes.
module tb_uart_reg_bank;

    localparam int unsigned NUM_REGS     = 4;
    localparam int unsigned NUM_KEYS     = 2;
    localparam int unsigned TIMEOUT_CLKS = 40;

    logic                  clk;
    logic                  rst_l;
    logic                  rx_dv;
    logic [7:0]            rx_byte;
    logic                  tx_done;
    logic                  tx_dv;
    logic [7:0]            tx_byte;
    logic [NUM_KEYS-1:0]   keys;
    logic [NUM_REGS*8-1:0] regs;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    uart_reg_bank #(
        .NUM_REGS     (NUM_REGS),
        .NUM_KEYS     (NUM_KEYS),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) dut (
        .i_Clock   (clk),
        .i_Rst_L   (rst_l),
        .i_RX_DV   (rx_dv),
        .i_RX_Byte (rx_byte),
        .i_TX_Done (tx_done),
        .o_TX_DV   (tx_dv),
        .o_TX_Byte (tx_byte),
        .i_Keys    (keys),
        .o_Regs    (regs),
        .o_Busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        step();
        rx_dv   = 1'b0;
    endtask

    // Wait for a response, check byte/latency, then complete the TX handshake
    task automatic expect_tx(input string tag, input logic [7:0] exp, input int lat);
        int n = 0;
        while (!tx_dv && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_dv"}, 32'(tx_dv), 32'd1);
        if (lat >= 0) chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_byte"}, 32'(tx_byte), 32'(exp));
        step();
        chk({tag, "_hold"}, 32'(tx_byte), 32'(exp));
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [7:0] hdr, input logic [7:0] exp);
        send_byte(hdr);
        expect_tx(tag, exp, 1);
    endtask

    initial begin
        int saw_tx;
        rst_l   = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        tx_done = 1'b0;
        keys    = 2'b00;
        repeat (3) step();
        chk("rst_regs", regs, 32'h0);
        chk("rst_txdv", 32'(tx_dv), 32'd0);
        chk("rst_txbyte", 32'(tx_byte), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_l = 1'b1;
        step();

        do_read("rd0", 8'h00, 8'h00);
        do_read("rd1", 8'h01, 8'h00);
        do_read("rd2", 8'h02, 8'h00);
        do_read("rd3", 8'h03, 8'h00);
        chk("regs_zero", regs, 32'h0);

        // Write reg1 = 0x5A
        send_byte(8'h81);
        chk("wr_busy", 32'(busy), 32'd1);
        send_byte(8'h5A);
        chk("wr_reg1", regs, 32'h0000_5A00);
        expect_tx("wr_echo", 8'h5A, -1);
        do_read("rd1b", 8'h01, 8'h5A);

        // Out-of-range write and malformed header
        send_byte(8'h85);
        send_byte(8'h11);
        expect_tx("wr_oor", 8'hEE, -1);
        chk("oor_regs", regs, 32'h0000_5A00);
        do_read("bad_hdr", 8'h30, 8'hEE);
        do_read("rd_oor", 8'h05, 8'hEE);

        // Inter-byte timeout: no response, back to IDLE, TOUT set
        send_byte(8'h82);
        saw_tx = 0;
        repeat (TIMEOUT_CLKS + 2) begin
            step();
            if (tx_dv) saw_tx = 1;
        end
        chk("tout_notx", 32'(saw_tx), 32'd0);
        chk("tout_idle", 32'(busy), 32'd0);
        chk("tout_regs", regs, 32'h0000_5A00);
        keys = 2'b10;
        do_read("stat_tout", 8'h0F, 8'h42);
        do_read("stat_clr", 8'h0F, 8'h02);

        // Overrun while waiting for TX done, both before and coincident with done
        send_byte(8'h00);
        step();
        chk("ovr_dv", 32'(tx_dv), 32'd1);
        chk("ovr_byte", 32'(tx_byte), 32'h00);
        rx_dv   = 1'b1;
        rx_byte = 8'h81;
        step();
        rx_dv   = 1'b0;
        chk("ovr_busy", 32'(busy), 32'd1);
        rx_dv   = 1'b1;
        rx_byte = 8'h81;
        tx_done = 1'b1;
        step();
        rx_dv   = 1'b0;
        tx_done = 1'b0;
        chk("ovr_idle", 32'(busy), 32'd0);
        step();
        chk("ovr_still_idle", 32'(busy), 32'd0);
        chk("ovr_regs", regs, 32'h0000_5A00);
        do_read("stat_ovr", 8'h0F, 8'h82);
        do_read("stat_ovr_clr", 8'h0F, 8'h02);

`ifdef UART_REG_BANK_CSUM_EN
        send_byte(8'h80);
        send_byte(8'h3C);
        chk("cs_pending", regs, 32'h0000_5A00);
        send_byte(8'hBC);
        chk("cs_wr", regs, 32'h0000_5A3C);
        expect_tx("cs_echo", 8'h3C, -1);
        send_byte(8'h80);
        send_byte(8'h3C);
        send_byte(8'h00);
        expect_tx("cs_bad", 8'hEC, -1);
        chk("cs_bad_regs", regs, 32'h0000_5A3C);
        do_read("stat_cserr", 8'h0F, 8'h22);
        do_read("stat_cs_clr", 8'h0F, 8'h02);
`else
        send_byte(8'h80);
        send_byte(8'h3C);
        chk("wr_reg0", regs, 32'h0000_5A3C);
        expect_tx("wr0_echo", 8'h3C, -1);
        do_read("stat_nocs", 8'h0F, 8'h02);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
